// File: rtl/ram_stream_reader_pkg.sv
// Shared types and latency constants for the RAM stream reader.
// RAM_STREAM_READER_LAT2_EN selects a RAM with an extra output register (2-cycle read latency).
package ram_stream_reader_pkg;

`ifdef RAM_STREAM_READER_LAT2_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    // One slot per in-flight read plus one so a beat can drain while the next lands.
    localparam int BUF_DEPTH = RD_LAT + 1;
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ram_stream_reader_skid_fifo.sv
// Small register FIFO that absorbs returning read data under consumer backpressure.
// Zero-latency head view; the caller guarantees no push when full, so there is no full flag.
module stream_skid_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    output logic [W-1:0]     head_dat,
    output logic             head_vld,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign head_vld = (cnt_q != '0);
    assign count    = cnt_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Sequential RAM reader presenting words as a valid/ready stream with a last-beat flag.
// Start -> first beat is RD_LAT+1 cycles; reads are credit-limited so consumer stalls never drop data.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LEN_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_raddr,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_tdata,
    output logic              o_tvalid,
    input  logic              i_tready,
    output logic              o_tlast
);
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [RD_LAT-1:0]   vld_pipe_q, vld_pipe_d;
    logic [RD_LAT-1:0]   last_pipe_q, last_pipe_d;
    logic                done_q, done_d;

    logic                issue;
    logic                pop;
    logic [CNT_W-1:0]    inflight;
    logic [CNT_W:0]      credit_used;
    logic [DATA_W:0]     head_dat;
    logic                head_vld;
    logic [CNT_W-1:0]    fifo_cnt;

    assign pop = head_vld & i_tready;

    always_comb begin
        state_d  = state_q;
        raddr_d  = raddr_q;
        rem_d    = rem_q;
        done_d   = 1'b0;

        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(vld_pipe_q[i]);
        end
        // A beat leaving this cycle frees its slot now, which is what sustains 1 beat/cycle.
        credit_used = {1'b0, fifo_cnt} + {1'b0, inflight} - (CNT_W + 1)'(pop);
        issue = (state_q == READ) && (rem_q != '0) && (credit_used < (CNT_W + 1)'(BUF_DEPTH));

        vld_pipe_d  = RD_LAT'({vld_pipe_q, issue});
        last_pipe_d = RD_LAT'({last_pipe_q, issue && (rem_q == LEN_W'(1))});

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (i_len != '0) begin
                        state_d = READ;
                        raddr_d = i_base_addr;
                        rem_d   = i_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    raddr_d = (raddr_q == ADDR_W'(DEPTH - 1)) ? '0 : raddr_q + ADDR_W'(1);
                    rem_d   = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && head_dat[DATA_W]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            raddr_q     <= '0;
            rem_q       <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            raddr_q     <= raddr_d;
            rem_q       <= rem_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
            done_q      <= done_d;
        end
    end

    stream_skid_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (vld_pipe_q[RD_LAT-1]),
        .push_dat ({last_pipe_q[RD_LAT-1], i_rdata}),
        .pop      (pop),
        .head_dat (head_dat),
        .head_vld (head_vld),
        .count    (fifo_cnt)
    );

    assign o_busy   = (state_q != IDLE);
    assign o_done   = done_q;
    assign o_raddr  = raddr_q;
    assign o_tvalid = head_vld;
    assign o_tdata  = head_dat[DATA_W-1:0];
    assign o_tlast  = head_vld & head_dat[DATA_W];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: directed transfers against a read-first RAM model.
module tb_ram_stream_reader;
    import ram_stream_reader_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int LEN_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic [ADDR_W-1:0] i_base_addr;
    logic [LEN_W-1:0]  i_len;
    logic              o_busy;
    logic              o_done;
    logic [ADDR_W-1:0] o_raddr;
    logic [DATA_W-1:0] i_rdata;
    logic [DATA_W-1:0] o_tdata;
    logic              o_tvalid;
    logic              i_tready;
    logic              o_tlast;

    ram_stream_reader #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_len(i_len), .o_busy(o_busy), .o_done(o_done), .o_raddr(o_raddr),
        .i_rdata(i_rdata), .o_tdata(o_tdata), .o_tvalid(o_tvalid),
        .i_tready(i_tready), .o_tlast(o_tlast)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [DEPTH];
    initial for (int k = 0; k < DEPTH; k++) mem[k] = 8'hA0 + 8'(k);

`ifdef RAM_STREAM_READER_LAT2_EN
    logic [DATA_W-1:0] ram_s1;
    always @(posedge clk) begin
        ram_s1  <= mem[o_raddr];
        i_rdata <= ram_s1;
    end
`else
    always @(posedge clk) i_rdata <= mem[o_raddr];
`endif

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;
    int first_vld_cyc = 0;
    int last_hs_cyc = 0;
    int last_done_cyc = 0;
    int done_cnt = 0;
    int hs_total = 0;
    logic [DATA_W:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops the scoreboard on every handshake and enforces hold-while-stalled.
    initial begin
        logic            in_xfer;
        logic            prev_hold;
        logic [DATA_W-1:0] prev_dat;
        logic            prev_last;
        logic [DATA_W:0] e;
        in_xfer   = 1'b0;
        prev_hold = 1'b0;
        prev_dat  = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_xfer   = 1'b0;
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk("hold_vld", o_tvalid, 1);
                    chk("hold_dat", o_tdata, prev_dat);
                    chk("hold_last", o_tlast, prev_last);
                end
                if (o_done) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                end
                if (o_tvalid && !in_xfer) begin
                    in_xfer = 1'b1;
                    first_vld_cyc = cyc;
                end
                if (o_tvalid && i_tready) begin
                    hs_total++;
                    chk("sb_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("tdata", o_tdata, e[DATA_W-1:0]);
                        chk("tlast", o_tlast, e[DATA_W]);
                    end
                    if (o_tlast) begin
                        last_hs_cyc = cyc;
                        in_xfer = 1'b0;
                    end
                end
                prev_hold = o_tvalid && !i_tready;
                prev_dat  = o_tdata;
                prev_last = o_tlast;
            end
        end
    end

    task automatic start_xfer(input int base, input int len, input bit accepted);
        i_start     = 1'b1;
        i_base_addr = ADDR_W'(base);
        i_len       = LEN_W'(len);
        if (accepted) begin
            start_cyc = cyc + 1;
            for (int k = 0; k < len; k++)
                exp_q.push_back({k == len - 1, mem[(base + k) % DEPTH]});
        end
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", done_cnt != d0, 1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_raddr"}, o_raddr, 0);
        chk({tag, "_tdata"}, o_tdata, 0);
        chk({tag, "_tvalid"}, o_tvalid, 0);
        chk({tag, "_tlast"}, o_tlast, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int h0;
        int n;
        bit [3:0] pat;
        pat = 4'b1001;
        rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_len = '0; i_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic: A2..A5 back to back, done one cycle after the last handshake.
        start_xfer(2, 4, 1);
        wait_done(40);
        chk("basic_latency", first_vld_cyc - start_cyc, RD_LAT + 1);
        chk("basic_span", last_hs_cyc - first_vld_cyc, 3);
        chk("basic_done_time", last_done_cyc - last_hs_cyc, 1);
        chk("basic_sb_empty", exp_q.size(), 0);
        chk("basic_idle", o_busy, 0);
        repeat (2) @(posedge clk); #1;

        // Wrap: 6,7,0,1,2.
        start_xfer(6, 5, 1);
        wait_done(40);
        chk("wrap_span", last_hs_cyc - first_vld_cyc, 4);
        chk("wrap_done_time", last_done_cyc - last_hs_cyc, 1);
        chk("wrap_raddr_end", o_raddr, 3);
        chk("wrap_sb_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk); #1;

        // Backpressure: ready 1,0,0,1 repeating.
        h0 = hs_total;
        d0 = done_cnt;
        start_xfer(0, 8, 1);
        n = 0;
        while (done_cnt == d0 && n < 200) begin
            i_tready = pat[n % 4];
            @(posedge clk); #1;
            n++;
        end
        i_tready = 1'b1;
        chk("bp_done_seen", done_cnt - d0, 1);
        chk("bp_beats", hs_total - h0, 8);
        chk("bp_sb_empty", exp_q.size(), 0);
        chk("bp_done_time", last_done_cyc - last_hs_cyc, 1);
        repeat (2) @(posedge clk); #1;

        // Zero length: single done pulse, never busy, no beats.
        d0 = done_cnt;
        h0 = hs_total;
        start_cyc = cyc + 1;
        start_xfer(5, 0, 0);
        for (int k = 0; k < 6; k++) begin
            chk("zl_busy", o_busy, 0);
            chk("zl_tvalid", o_tvalid, 0);
            @(posedge clk); #1;
        end
        chk("zl_done_count", done_cnt - d0, 1);
        chk("zl_done_time", last_done_cyc, start_cyc);
        chk("zl_beats", hs_total - h0, 0);

        // Start while busy is ignored.
        h0 = hs_total;
        start_xfer(3, 4, 1);
        start_xfer(0, 2, 0);
        wait_done(40);
        d0 = done_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("sb_beats", hs_total - h0, 4);
        chk("sb_no_restart", done_cnt - d0, 0);
        chk("sb_raddr_end", o_raddr, 7);
        chk("sb_sb_empty", exp_q.size(), 0);

        // Reset after the 2nd beat of a 6-beat transfer.
        h0 = hs_total;
        start_xfer(0, 6, 1);
        n = 0;
        while (hs_total < h0 + 2 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_reached_beat2", hs_total >= h0 + 2, 1);
        rst = 1'b1;
        #1;
        chk_outputs_zero("midrst");
        exp_q.delete();
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_done", done_cnt - d0, 0);
        h0 = hs_total;
        start_xfer(1, 2, 1);
        wait_done(40);
        chk("post_rst_beats", hs_total - h0, 2);
        chk("post_rst_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side engine for the team's dual-port block RAM. Given a base address and a beat count, it issues sequential reads on the RAM read port (registered read data, 1-cycle latency).
- It presents the returned words as a valid/ready stream with a last-beat flag.
- Sits between a RAM filled by a writer agent and any downstream stream consumer. It absorbs consumer backpressure without losing in-flight read data.

Parameters:
- DATA_W, 8, data width; must match the RAM.
- DEPTH, 8, RAM depth in words; need not be a power of two.
- ADDR_W, $clog2(DEPTH), address width (dependent).
- LEN_W, $clog2(DEPTH)+1, width of the beat-count input (dependent).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- i_start  input  1  start pulse; sampled only in IDLE
- i_base_addr  input  ADDR_W  first RAM address; captured on accepted start
- i_len  input  LEN_W  number of beats; captured on accepted start
- o_busy  output  1  high from accepted start until the last beat handshakes
- o_done  output  1  single-cycle pulse when a transfer completes
- o_raddr  output  ADDR_W  RAM read address
- i_rdata  input  DATA_W  RAM read data; valid 1 cycle after o_raddr is presented
- o_tdata  output  DATA_W  stream data
- o_tvalid  output  1  stream valid
- i_tready  input  1  stream ready
- o_tlast  output  1  high with the final beat of a transfer

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst is asynchronous and active-high.
  - All of the following reset to 0: o_busy, o_done, o_raddr, o_tdata, o_tvalid, o_tlast, internal counters, buffer occupancy.
- States:
  - IDLE -> READ: on i_start with i_len != 0.
  - IDLE -> IDLE with o_done pulsed next cycle: on i_start with i_len == 0. No beats are emitted; o_busy stays 0.
  - READ -> DRAIN: once i_len reads have been issued.
  - DRAIN -> IDLE: when the last beat handshakes (o_tvalid & i_tready & o_tlast). o_done pulses in the same cycle as that handshake is registered, i.e. the cycle after it.
- Read issue:
  - A read is issued in a cycle when in READ, reads remain, and (in-flight + buffered) < 2.
  - o_raddr updates to the next address on each issue. It holds its value otherwise.
  - Address increments by 1 and wraps DEPTH-1 -> 0.
  - i_len > DEPTH is legal; addresses re-wrap and words are re-read.
- Buffering:
  - 2-entry output FIFO (skid) captures i_rdata one cycle after each issue.
  - The credit rule guarantees it never overflows.
  - With i_tready held high, throughput is 1 beat/cycle after an initial 2-cycle latency (start -> first o_tvalid).
- Stream rules:
  - Once o_tvalid is asserted, o_tdata and o_tlast are held stable until the handshake.
  - o_tvalid never drops without a handshake.
  - o_tlast is asserted only with the beat of index i_len-1.
- Start while busy is ignored; captured base and length are unaffected.
- Reset mid-transfer aborts immediately:
  - No o_done is issued.
  - The buffer is flushed.
  - The next transfer starts clean.
- The engine never drives a write port; RAM write-side activity is outside its scope. Reading an address written in the same cycle returns the old data (RAM read-first behaviour).

Optional Feature:
- Macro: RAM_STREAM_READER_LAT2_EN.
- Defined:
  - Read latency is 2 cycles, for a RAM with an extra output register.
  - Capture pipeline is 2 stages and the skid FIFO has 3 entries.
  - Credit limit is 3.
  - Start -> first o_tvalid is 3 cycles.
  - Full throughput is still 1 beat/cycle.
- Undefined: latency 1, 2 entries, credit limit 2, as above.

Decomposition:
- Package ram_stream_reader_pkg:
  - State enum: IDLE, READ, DRAIN.
  - Constant RD_LAT: 1, or 2 when the macro is defined.
  - Constant BUF_DEPTH = RD_LAT + 1.
- Natural sub-module: stream_skid_fifo, a small parameterised BUF_DEPTH-entry register FIFO with occupancy output.
- The top keeps the FSM, address/length counters, credit check and latency valid-shift.

Test Plan:
- Basic: RAM preloaded with word k = 8'hA0+k, base=2, len=4, i_tready=1 -> beats A2,A3,A4,A5 on consecutive cycles; o_tlast on A5; o_done one cycle after the A5 handshake.
- Wrap: base=6, len=5, DEPTH=8 -> o_raddr sequence 6,7,0,1,2; data A6,A7,A0,A1,A2.
- Backpressure: len=8; i_tready toggles 1,0,0,1 repeatedly -> all 8 beats delivered in order; no beat lost or duplicated; o_tdata stable while valid & !ready; buffer never exceeds 2.
- Zero length: start with len=0 -> no o_tvalid; o_done high exactly 1 cycle; o_busy stays 0.
- Start while busy: second start (base=0, len=2) mid-transfer -> ignored; the original transfer completes unchanged.
- Reset mid-transfer: assert rst after the 2nd beat of len=6 -> all outputs 0 immediately; no o_done; a following transfer with base=1, len=2 yields A1,A2 correctly.
